// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - execute-stage divide request/response bundle
interface div_unit_if;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stall_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stall_o
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed/unsigned restoring radix-2 divider, 32-cycle
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } stateT;

    stateT       state;
    logic [5:0]  counter;
    logic [64:0] work;        // {remainder[64:33], next dividend bit / quotient bits [32:0]}
    logic [31:0] divisor;
    logic        op1Neg;
    logic        op2Neg;
    logic        readyQ;
    logic [63:0] resultQ;

    logic [31:0] op1Mag;
    logic [31:0] op2Mag;
    logic [32:0] minuend;
    logic        takeStep;
    logic [31:0] diff;
    logic [64:0] nextWork;
    logic [31:0] quoFix;
    logic [31:0] remFix;

    // Operand magnitudes; only negative values of a signed divide are negated
    always_comb begin
        op1Mag = (bus.signed_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
        op2Mag = (bus.signed_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    end

    // One restoring step; the compare uses 33 bits because the shifted remainder can exceed 32 bits
    always_comb begin
        minuend  = work[64:32];
        takeStep = (minuend >= {1'b0, divisor});
        diff     = minuend[31:0] - divisor;
        if (takeStep) begin
            nextWork = {diff, work[31:0], 1'b1};
        end else begin
            nextWork = {work[63:0], 1'b0};
        end
        quoFix = (op1Neg ^ op2Neg) ? (~nextWork[31:0] + 32'd1) : nextWork[31:0];
        remFix = op1Neg ? (~nextWork[64:33] + 32'd1) : nextWork[64:33];
    end

    // Divide sequencer; flush beats a held request, result is cleared whenever not ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= 6'd0;
            work    <= 65'd0;
            divisor <= 32'd0;
            op1Neg  <= 1'b0;
            op2Neg  <= 1'b0;
            readyQ  <= 1'b0;
            resultQ <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    readyQ  <= 1'b0;
                    resultQ <= 64'd0;
                    if (bus.start_i && !bus.annul_i) begin
                        op1Neg  <= bus.signed_i & bus.opdata1_i[31];
                        op2Neg  <= bus.signed_i & bus.opdata2_i[31];
                        divisor <= op2Mag;
                        work    <= {32'd0, op1Mag, 1'b0};
                        counter <= 6'd0;
                        state   <= (bus.opdata2_i == 32'd0) ? DIVZERO : ON;
                    end
                end
                DIVZERO: begin
                    // Zero result is published from END on the following edge
                    resultQ <= 64'd0;
                    readyQ  <= 1'b0;
                    state   <= bus.annul_i ? IDLE : END;
                end
                ON: begin
                    if (bus.annul_i) begin
                        state   <= IDLE;
                        readyQ  <= 1'b0;
                        resultQ <= 64'd0;
                    end else begin
                        work    <= nextWork;
                        counter <= counter + 6'd1;
                        if (counter == 6'd31) begin
                            state   <= END;
                            readyQ  <= 1'b1;
                            resultQ <= {remFix, quoFix};
                        end
                    end
                end
                END: begin
                    if (bus.annul_i || !bus.start_i) begin
                        state   <= IDLE;
                        readyQ  <= 1'b0;
                        resultQ <= 64'd0;
                    end else begin
                        readyQ <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_o  = readyQ;
    assign bus.result_o = resultQ;
    assign bus.stall_o  = bus.start_i & ~readyQ;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int N = 11;
    logic [31:0] tA   [N] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd7, 32'h12345678, 32'hDEADBEEF, 32'hFFFFFFFB,
                              32'hFFFFFFF9};
    logic [31:0] tB   [N] = '{32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd1,
                              32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00001000, 32'd0, 32'd0,
                              32'hFFFFFFFE};
    logic        tS   [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] tRes [N] = '{{32'd2, 32'hE}, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'h7FFFFFFC},
                              {32'd0, 32'h80000000}, {32'd0, 32'hFFFFFFFF}, {32'd1, 32'd1},
                              {32'd1, 32'hFFFFFFFD}, {32'h678, 32'h12345}, 64'd0, 64'd0,
                              {32'hFFFFFFFF, 32'd3}};
    int          tCyc [N] = '{32, 32, 32, 32, 32, 32, 32, 32, 2, 2, 32};

    task automatic test_reset;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        bus.annul_i   = 1'b0;
        rst = 1'b0;
        #12;
        checks++;
        if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.ready_o); end
        checks++;
        if (bus.result_o !== 64'd0) begin failures++; $display("FAIL rst_result got=%h exp=0", bus.result_o); end
        checks++;
        if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall0 got=%b exp=0", bus.stall_o); end
        bus.start_i = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL rst_stall1 got=%b exp=1", bus.stall_o); end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL post_rst_ready got=%b exp=0", bus.ready_o); end
    endtask

    task automatic test_stall_latency;
        int bad;
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL stall_idle got=%b exp=1", bus.stall_o); end
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0 || bus.stall_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_window bad_cycles=%0d exp=0", bad); end
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1 || bus.stall_o !== 1'b0)
            begin failures++; $display("FAIL stall_done ready=%b stall=%b exp ready=1 stall=0", bus.ready_o, bus.stall_o); end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.result_o !== {32'd2, 32'hE} || bus.ready_o !== 1'b1)
            begin failures++; $display("FAIL hold_result got=%h exp=%h", bus.result_o, {32'd2, 32'hE}); end
        bus.start_i = 1'b0;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL stall_drop got=%b exp=0", bus.stall_o); end
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            begin failures++; $display("FAIL release ready=%b result=%h exp 0", bus.ready_o, bus.result_o); end
    endtask

    task automatic test_div_table;
        int cyc;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.start_i = 1'b1; bus.signed_i = tS[i]; bus.opdata1_i = tA[i]; bus.opdata2_i = tB[i];
            @(negedge clk);
            cyc = 0;
            while (bus.ready_o !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != tCyc[i]) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, cyc, tCyc[i]); end
            checks++;
            if (bus.result_o !== tRes[i]) begin failures++; $display("FAIL vec%0d_result got=%h exp=%h", i, bus.result_o, tRes[i]); end
            // operand changes after capture must not disturb the held result
            bus.opdata1_i = 32'h0BADF00D; bus.opdata2_i = 32'd3;
            @(negedge clk);
            checks++;
            if (bus.result_o !== tRes[i] || bus.ready_o !== 1'b1)
                begin failures++; $display("FAIL vec%0d_hold got=%h exp=%h", i, bus.result_o, tRes[i]); end
            bus.start_i = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
                begin failures++; $display("FAIL vec%0d_idle ready=%b result=%h exp 0", i, bus.ready_o, bus.result_o); end
        end
    endtask

    task automatic test_annul;
        int seen;
        int cyc;
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
        @(negedge clk);
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL annul_on got=%b exp=0", bus.ready_o); end
        repeat (2) @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL annul_no_ready got=%0d exp=0", seen); end
        bus.start_i = 1'b1; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
        @(negedge clk);
        cyc = 0;
        while (bus.ready_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 32 || bus.result_o !== {32'd0, 32'd3})
            begin failures++; $display("FAIL annul_next cyc=%0d result=%h exp 32 %h", cyc, bus.result_o, {32'd0, 32'd3}); end
        bus.annul_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            begin failures++; $display("FAIL annul_end ready=%b result=%h exp 0", bus.ready_o, bus.result_o); end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int cyc;
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        @(negedge clk);
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            begin failures++; $display("FAIL arst_mid ready=%b result=%h exp 0", bus.ready_o, bus.result_o); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (bus.ready_o !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 32 || bus.result_o !== {32'd2, 32'hE})
            begin failures++; $display("FAIL arst_fresh cyc=%0d result=%h exp 32 %h", cyc, bus.result_o, {32'd2, 32'hE}); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0)
            begin failures++; $display("FAIL arst_end ready=%b result=%h exp 0", bus.ready_o, bus.result_o); end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL arst_idle got=%b exp=0", bus.ready_o); end
    endtask

    initial begin
        test_reset();
        test_stall_latency();
        test_div_table();
        test_annul();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
